afu_job_sequencer: RTL and testbench

//  Per-job sequencer behind the PSL control interface. On a start pulse it:

---
 rtl/afu_job_sequencer.sv | 150 +++++++++++++++
 tb/tb_afu_job_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/afu_job_sequencer.sv
// afu_job_sequencer: per-job WED fetch, pre-MMIO, read/write DMA issue, completion wait, post-MMIO and done report.
// Address and data buses use big-endian bit numbering: bit 0 is the MSB.
module afu_job_sequencer #(
  parameter logic [12:0] READ_CL_NA = 13'h0A00,
  parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
  input  logic          ha_pclock,
  input  logic          reset,
  input  logic          start,
  input  logic [0:63]   wed_ea,
  input  logic          misc_ready,
  output logic          misc_req,
  output logic [0:56]   misc_addr,
  output logic [12:0]   misc_com,
  input  logic          misc_done,
  input  logic [0:1023] misc_rd_data,
  output logic          start_premmio,
  input  logic          done_premmio,
  input  logic          read_ready,
  output logic          read_req,
  output logic [0:63]   read_addr,
  output logic [0:63]   read_size,
  input  logic          write_ready,
  output logic          write_req,
  output logic [0:63]   write_addr,
  output logic [0:63]   write_size,
  input  logic          dma_done,
  output logic          start_postmmio,
  input  logic          done_postmmio,
  output logic          busy,
  output logic          job_done,
  output logic [1:0]    job_err
);
  typedef enum logic [8:0] {
    IDLE     = 9'h001,
    WED_REQ  = 9'h002,
    WED_WAIT = 9'h004,
    PRE      = 9'h008,
    RD_REQ   = 9'h010,
    WR_REQ   = 9'h020,
    RUN      = 9'h040,
    POST     = 9'h080,
    DONE     = 9'h100
  } state_t;
  state_t state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [0:255] wed_q, wed_d;
  logic [0:56] misc_addr_q, misc_addr_d;
  logic [1:0] err_q, err_d;
  logic [12:0] misc_com_q, misc_com_d;
  logic misc_req_q, misc_req_d, read_req_q, read_req_d, write_req_q, write_req_d;
  logic pre_q, pre_d, post_q, post_d, busy_q, busy_d, done_q, done_d;
  logic timed_out;
  logic unused_wed_tail;
  assign unused_wed_tail = ^misc_rd_data[256:1023];
  always_comb begin
    state_d     = state_q;
    wed_d       = wed_q;
    misc_addr_d = misc_addr_q;
    err_d       = err_q;
    timed_out   = TIMEOUT != 24'd0 && (state_q inside {WED_WAIT, PRE, RUN, POST})
                  && cnt_q == TIMEOUT - 24'd1;
    case (state_q)
      IDLE: if (start) begin
        misc_addr_d = wed_ea[0:56];
        err_d       = {1'b0, |wed_ea[57:63]};
        if (|wed_ea[57:63]) state_d = DONE;
        else state_d = WED_REQ;
      end
      WED_REQ:  if (misc_ready) state_d = WED_WAIT;
      WED_WAIT: if (misc_done) begin
        wed_d   = misc_rd_data[0:255];
        state_d = PRE;
      end
      PRE: if (done_premmio) begin
        if (|wed_q[64:127]) state_d = RD_REQ;
        else if (|wed_q[192:255]) state_d = WR_REQ;
        else state_d = POST;
      end
      RD_REQ: if (read_ready) begin
        if (|wed_q[192:255]) state_d = WR_REQ;
        else state_d = RUN;
      end
      WR_REQ:  if (write_ready) state_d = RUN;
      RUN:     if (dma_done) state_d = POST;
      POST:    if (done_postmmio) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a response landing on the final permitted cycle still wins over the timeout
    if (timed_out && state_d == state_q) begin
      state_d = DONE;
      err_d   = 2'b10;
    end
    cnt_d       = state_d != state_q ? 24'd0 : cnt_q + 24'd1;
    misc_req_d  = state_d == WED_REQ;
    misc_com_d  = misc_req_d ? READ_CL_NA : 13'd0;
    read_req_d  = state_d == RD_REQ;
    write_req_d = state_d == WR_REQ;
    pre_d       = state_d == PRE && state_q != PRE;
    post_d      = state_d == POST && state_q != POST;
    busy_d      = state_d != IDLE && state_d != DONE;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge ha_pclock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wed_q       <= '0;
      misc_addr_q <= '0;
      err_q       <= '0;
      misc_com_q  <= '0;
      misc_req_q  <= 1'b0;
      read_req_q  <= 1'b0;
      write_req_q <= 1'b0;
      pre_q       <= 1'b0;
      post_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wed_q       <= wed_d;
      misc_addr_q <= misc_addr_d;
      err_q       <= err_d;
      misc_com_q  <= misc_com_d;
      misc_req_q  <= misc_req_d;
      read_req_q  <= read_req_d;
      write_req_q <= write_req_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign misc_req       = misc_req_q;
  assign misc_addr      = misc_addr_q;
  assign misc_com       = misc_com_q;
  assign start_premmio  = pre_q;
  assign read_req       = read_req_q;
  assign read_addr      = wed_q[0:63];
  assign read_size      = wed_q[64:127];
  assign write_req      = write_req_q;
  assign write_addr     = wed_q[128:191];
  assign write_size     = wed_q[192:255];
  assign start_postmmio = post_q;
  assign busy           = busy_q;
  assign job_done       = done_q;
  assign job_err        = err_q;
endmodule

// File: tb/tb_afu_job_sequencer.sv
// tb_afu_job_sequencer: randomized jobs checked every cycle against a timeline model of phase entry/exit cycles.
module tb_afu_job_sequencer;
  localparam int T = 16;
  localparam int NEVER = 100000;
  logic ha_pclock = 1'b0, reset = 1'b1;
  logic start = 0, misc_ready = 0, misc_done = 0, done_premmio = 0;
  logic read_ready = 0, write_ready = 0, dma_done = 0, done_postmmio = 0;
  logic [63:0] wed_ea = '0;
  logic [1023:0] misc_rd_data = '0;
  logic misc_req, start_premmio, read_req, write_req, start_postmmio, busy, job_done;
  logic [56:0] misc_addr;
  logic [12:0] misc_com;
  logic [63:0] read_addr, read_size, write_addr, write_size;
  logic [1:0] job_err;
  afu_job_sequencer #(.TIMEOUT(24'd16)) dut (
    .ha_pclock(ha_pclock), .reset(reset), .start(start), .wed_ea(wed_ea),
    .misc_ready(misc_ready), .misc_req(misc_req), .misc_addr(misc_addr), .misc_com(misc_com),
    .misc_done(misc_done), .misc_rd_data(misc_rd_data),
    .start_premmio(start_premmio), .done_premmio(done_premmio),
    .read_ready(read_ready), .read_req(read_req), .read_addr(read_addr), .read_size(read_size),
    .write_ready(write_ready), .write_req(write_req), .write_addr(write_addr), .write_size(write_size),
    .dma_done(dma_done), .start_postmmio(start_postmmio), .done_postmmio(done_postmmio),
    .busy(busy), .job_done(job_done), .job_err(job_err)
  );
  always #5 ha_pclock = ~ha_pclock;
  int vecs = 0, errs = 0;
  int a_m, e_pre, r_wed, r_pre, e_rd, acc_rd, e_wr, acc_wr, e_run, r_run, e_post, r_post, e_done;
  int sps, sp_dma, sp_post, cur_t;
  int obs_done, obs_rn, obs_wf, obs_sp, obs_mn;
  logic [1:0] err_f;
  logic [63:0] n_ra, n_rs, n_wa, n_ws, o_ra = '0, o_rs = '0, o_wa = '0, o_ws = '0;
  bit active = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // Turn response delays into the cycle each phase starts and ends; a wait longer than T times out.
  task automatic plan(input bit mis, input int rm, dw, dp, rr, wr, dd, dq);
    int e;
    {e_pre, r_wed, r_pre, e_rd, acc_rd, e_wr, acc_wr} = {7{NEVER}};
    {e_run, r_run, e_post, r_post} = {4{NEVER}};
    a_m = 0;
    err_f = 2'b00;
    if (mis) begin e_done = 0; err_f = 2'b01; return; end
    a_m = 1 + rm;
    e = a_m;
    if (dw > T) begin e_done = e + T; err_f = 2'b10; return; end
    r_wed = e + dw; e_pre = r_wed; e = e_pre;
    if (dp > T) begin e_done = e + T; err_f = 2'b10; return; end
    r_pre = e + dp; e = r_pre;
    if (n_rs != 0) begin e_rd = e; acc_rd = e + 1 + rr; e = acc_rd; end
    if (n_ws != 0) begin e_wr = e; acc_wr = e + 1 + wr; e = acc_wr; end
    if (n_rs != 0 || n_ws != 0) begin
      e_run = e;
      if (dd > T) begin e_done = e + T; err_f = 2'b10; return; end
      r_run = e + dd; e = r_run;
    end
    e_post = e;
    if (dq > T) begin e_done = e + T; err_f = 2'b10; return; end
    r_post = e + dq; e_done = r_post;
  endtask
  always @(negedge ha_pclock) if (active) begin
    int t;
    t = cur_t;
    chk("misc_req", misc_req, t < a_m);
    chk("misc_com", misc_com, t < a_m ? 13'h0A00 : 13'h0);
    chk("misc_addr", misc_addr, wed_ea[63:7]);
    chk("start_premmio", start_premmio, t == e_pre);
    chk("read_req", read_req, t >= e_rd && t < acc_rd);
    chk("read_addr", read_addr, t >= e_pre ? n_ra : o_ra);
    chk("read_size", read_size, t >= e_pre ? n_rs : o_rs);
    chk("write_req", write_req, t >= e_wr && t < acc_wr);
    chk("write_addr", write_addr, t >= e_pre ? n_wa : o_wa);
    chk("write_size", write_size, t >= e_pre ? n_ws : o_ws);
    chk("start_postmmio", start_postmmio, t == e_post);
    chk("busy", busy, t < e_done);
    chk("job_done", job_done, t == e_done);
    chk("job_err", job_err, t >= e_done ? err_f : 2'b00);
    if (job_done && obs_done < 0) obs_done = t;
    if (write_req && obs_wf < 0) obs_wf = t;
    if (start_postmmio && obs_sp < 0) obs_sp = t;
    if (read_req) obs_rn++;
    if (misc_req) obs_mn++;
  end
  function automatic logic rnd();
    return $urandom_range(0, 1) == 1;
  endfunction
  task automatic drive(input int t);
    start         = t == 0 || t == sps;
    misc_ready    = t == a_m || ((t == 0 || t > a_m) && rnd());
    misc_done     = t == r_wed || t == e_done + 1;
    done_premmio  = t == r_pre || t == e_done + 1;
    read_ready    = t == acc_rd || ((t <= e_rd || t > acc_rd) && rnd());
    write_ready   = t == acc_wr || ((t <= e_wr || t > acc_wr) && rnd());
    dma_done      = t == r_run || t == e_done + 1 || t == sp_dma;
    done_postmmio = t == r_post || t == e_done + 1 || t == sp_post;
  endtask
  task automatic run_job(input int gap, input int abort, input int force_sps);
    int last;
    sps = force_sps >= 0 ? force_sps : $urandom_range(1, e_done + 1);
    sp_dma = $urandom_range(0, e_run < e_done ? e_run : e_done);
    sp_post = $urandom_range(0, e_post < e_done ? e_post : e_done);
    misc_rd_data = {n_ra, n_rs, n_wa, n_ws, {24{$urandom()}}};
    {obs_done, obs_wf, obs_sp} = {3{-1}};
    {obs_rn, obs_mn} = {2{0}};
    last = abort >= 0 ? abort : e_done + gap;
    for (int t = 0; t <= last; t++) begin
      drive(t);
      @(posedge ha_pclock);
      cur_t = t;
      active = 1;
      @(negedge ha_pclock);
      #1;
    end
    active = 0;
    {start, misc_ready, misc_done, done_premmio, read_ready, write_ready, dma_done, done_postmmio} = '0;
    if (abort < 0 && e_pre < NEVER) {o_ra, o_rs, o_wa, o_ws} = {n_ra, n_rs, n_wa, n_ws};
  endtask
  task automatic set_wed(input logic [63:0] ea, ra, rs, wa, ws);
    wed_ea = ea; n_ra = ra; n_rs = rs; n_wa = wa; n_ws = ws;
  endtask
  function automatic int pick();
    int r;
    r = $urandom_range(0, 19);
    return r == 0 ? 20 : r == 1 ? 16 : $urandom_range(1, 6);
  endfunction
  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_misc_req", misc_req, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_job_err", job_err, 0);
    chk("rst_read_addr", read_addr, 0);
    repeat (2) @(negedge ha_pclock);
    reset = 0;
    #1;
    set_wed(64'h1000, 64'h2000, 64'd256, 64'h3000, 64'd128);
    plan(0, 0, 1, 1, 0, 0, 1, 1);
    run_job(2, -1, -1);
    chk("t1_done_cycle", obs_done, 7);
    chk("t1_misc_req_cycles", obs_mn, 1);
    plan(0, 0, 1, 1, 20, 0, 1, 1);
    run_job(2, -1, -1);
    chk("t2_read_req_cycles", obs_rn, 21);
    chk("t2_first_write_req", obs_wf, 24);
    chk("t2_read_addr", read_addr, 64'h2000);
    set_wed(64'h1000, 64'h0, 64'h0, 64'h0, 64'h0);
    plan(0, 0, 1, 1, 0, 0, 1, 1);
    run_job(2, -1, -1);
    chk("t3_read_req_cycles", obs_rn, 0);
    chk("t3_postmmio_cycle", obs_sp, 3);
    chk("t3_done_cycle", obs_done, 4);
    set_wed(64'h1004, 64'h2000, 64'd256, 64'h3000, 64'd128);
    plan(1, 0, 0, 0, 0, 0, 0, 0);
    run_job(2, -1, -1);
    chk("t4_misc_req_cycles", obs_mn, 0);
    chk("t4_done_cycle", obs_done, 0);
    chk("t4_job_err", job_err, 2'b01);
    set_wed(64'h1000, 64'h2000, 64'd256, 64'h3000, 64'd128);
    plan(0, 0, 1, 1, 0, 0, 99, 1);
    run_job(2, -1, -1);
    chk("t5_done_cycle", obs_done, 21);
    chk("t5_job_err", job_err, 2'b10);
    plan(0, 0, 1, 1, 0, 0, 10, 1);
    run_job(0, 8, 3);
    reset = 1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_read_req", read_req, 0);
    chk("t6_write_req", write_req, 0);
    chk("t6_job_done", job_done, 0);
    chk("t6_read_addr", read_addr, 0);
    chk("t6_misc_addr", misc_addr, 0);
    @(negedge ha_pclock);
    reset = 0;
    {o_ra, o_rs, o_wa, o_ws} = '0;
    repeat (3) begin
      @(negedge ha_pclock);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_done", job_done, 0);
      chk("t6_idle_misc_req", misc_req, 0);
    end
    #1;
    for (int j = 0; j < 40; j++) begin
      bit mis;
      logic [63:0] ea;
      mis = $urandom_range(0, 7) == 0;
      ea = {$urandom(), $urandom()};
      ea[6:0] = mis ? 7'($urandom_range(1, 127)) : 7'd0;
      set_wed(ea, {$urandom(), $urandom()},
              $urandom_range(0, 3) == 0 ? 64'd0 : {$urandom(), $urandom()},
              {$urandom(), $urandom()},
              $urandom_range(0, 3) == 0 ? 64'd0 : {$urandom(), $urandom()});
      plan(mis, $urandom_range(0, 9) == 0 ? 20 : $urandom_range(0, 3), pick(), pick(),
           $urandom_range(0, 4), $urandom_range(0, 4), pick(), pick());
      run_job($urandom_range(1, 3), -1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
